// File: rtl/npc_pkg.sv
// Shared NPC core definitions used by the load/store unit: access-size
// encodings, the LSU state type and the local access-legality check.
package npc_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_t;

    // True when an access must be trapped locally: unknown size, unsigned
    // store, or an address not aligned to the access size.
    function automatic logic lsu_access_err(input logic [2:0] funct3, input logic we,
                                            input logic [1:0] off);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_BU:   err = we;
            F3_H:    err = off[0];
            F3_HU:   err = we | off[0];
            F3_W:    err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side bus signals of the LSU.
// slave is the LSU's own view; master is the view of its environment.
interface lsu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_we;
    logic [2:0]            req_funct3;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [3:0]            mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_funct3,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_funct3,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU. Store side builds the write strobes and
// lane-replicated data; load side extracts and extends the addressed field.
// Purely combinational.
module lsu_align
    import npc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [1:0]            off,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            wmask,
    output logic [DATA_WIDTH-1:0] lane_wdata,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    // Store strobes and lane replication by access size.
    always_comb begin
        wmask      = 4'b0000;
        lane_wdata = wdata;
        case (funct3)
            F3_B: begin
                wmask      = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
            end
            F3_H: begin
                wmask      = 4'b0011 << off;
                lane_wdata = {2{wdata[15:0]}};
            end
            F3_W:    wmask = 4'b1111;
            default: ;
        endcase
    end

    // Load field extraction with sign or zero extension.
    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{(DATA_WIDTH - 8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(DATA_WIDTH - 16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {{(DATA_WIDTH - 8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(DATA_WIDTH - 16){1'b0}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one word-aligned memory transaction in flight at a time,
// illegal or misaligned accesses trapped locally without touching the bus.
// Every output is a register written by the FSM below.
module lsu
    import npc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);

    lsu_state_t            state_q;
    logic [1:0]            off_q;
    logic [2:0]            funct3_q;
    logic                  we_q;

    logic [1:0]            align_off;
    logic [2:0]            align_funct3;
    logic [3:0]            st_wmask;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  req_err;

    // Store lanes are decoded from the live request while idle; afterwards the
    // aligner sees the latched access so the load side can extract the field.
    always_comb begin
        if (state_q == StIdle) begin
            align_off    = bus.req_addr[1:0];
            align_funct3 = bus.req_funct3;
        end else begin
            align_off    = off_q;
            align_funct3 = funct3_q;
        end
    end

    assign req_err = lsu_access_err(bus.req_funct3, bus.req_we, bus.req_addr[1:0]);

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .off       (align_off),
        .funct3    (align_funct3),
        .wdata     (bus.req_wdata),
        .rdata     (bus.mem_rdata),
        .wmask     (st_wmask),
        .lane_wdata(st_wdata),
        .load_data (ld_data)
    );

    // Transaction FSM with registered handshake, bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= StIdle;
            off_q             <= '0;
            funct3_q          <= '0;
            we_q              <= 1'b0;
            bus.req_ready     <= 1'b1;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_data      <= '0;
            bus.rsp_err       <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wen       <= 1'b0;
            bus.mem_wmask     <= '0;
            bus.mem_wdata     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        off_q         <= bus.req_addr[1:0];
                        funct3_q      <= bus.req_funct3;
                        we_q          <= bus.req_we;
                        bus.req_ready <= 1'b0;
                        if (req_err) begin
                            state_q       <= StResp;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_data  <= '0;
                        end else begin
                            state_q           <= StReq;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_addr      <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus.mem_wen       <= bus.req_we;
                            bus.mem_wmask     <= bus.req_we ? st_wmask : 4'b0000;
                            bus.mem_wdata     <= bus.req_we ? st_wdata : '0;
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_req_ready) begin
                        state_q           <= StWait;
                        bus.mem_req_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus.mem_rsp_valid) begin
                        state_q       <= StResp;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_data  <= we_q ? '0 : ld_data;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q       <= StIdle;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_data  <= '0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: drives accesses from the core side, acts as
// the memory, and compares responses against a queue of expected results.
module tb_lsu;
    import npc_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    rsp_t sb_q[$];

    lsu_if bus ();

    lsu dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 32'd1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 32'd0);
        check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
        check({tag, "_rsp_err"}, bus.rsp_err, 32'd0);
        check({tag, "_mem_req_valid"}, bus.mem_req_valid, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wen"}, bus.mem_wen, 32'd0);
        check({tag, "_mem_wmask"}, {28'd0, bus.mem_wmask}, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    // One full access starting at a negedge with req_ready high; ends at a
    // negedge right after the response handshake.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [2:0] f3, input logic [31:0] rdata,
                           input int req_stall, input int rsp_stall, input logic exp_err,
                           input logic [31:0] exp_data, input logic [31:0] exp_maddr,
                           input logic [3:0] exp_mask, input logic [31:0] exp_mwdata);
        rsp_t e;
        check({tag, "_ready_idle"}, bus.req_ready, 32'd1);
        check({tag, "_rsp_idle"}, bus.rsp_valid, 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        sb_q.push_back('{err: exp_err, data: exp_data});
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.req_funct3 = 3'($urandom_range(7));
        check({tag, "_ready_busy"}, bus.req_ready, 32'd0);
        if (exp_err) begin
            check({tag, "_err_no_bus"}, bus.mem_req_valid, 32'd0);
            check({tag, "_err_rsp_t1"}, bus.rsp_valid, 32'd1);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                check({tag, "_mreq_valid"}, bus.mem_req_valid, 32'd1);
                check({tag, "_maddr"}, bus.mem_addr, exp_maddr);
                check({tag, "_mwen"}, bus.mem_wen, {31'd0, we});
                if (we) begin
                    check({tag, "_mwmask"}, {28'd0, bus.mem_wmask}, {28'd0, exp_mask});
                    check({tag, "_mwdata"}, bus.mem_wdata, exp_mwdata);
                end
                check({tag, "_rsp_in_req"}, bus.rsp_valid, 32'd0);
                if (i < req_stall) begin
                    // A stray response while the request is pending must be ignored.
                    bus.mem_rsp_valid = 1'b1;
                    @(negedge clk);
                    bus.mem_rsp_valid = 1'b0;
                end
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check({tag, "_mreq_drop"}, bus.mem_req_valid, 32'd0);
            check({tag, "_rsp_in_wait"}, bus.rsp_valid, 32'd0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = rdata;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rdata     = $urandom;
            check({tag, "_rsp_t3"}, bus.rsp_valid, 32'd1);
            check({tag, "_no_mreq"}, bus.mem_req_valid, 32'd0);
        end
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            for (int i = 0; i <= rsp_stall; i++) begin
                check({tag, "_rsp_valid"}, bus.rsp_valid, 32'd1);
                check({tag, "_rsp_data"}, bus.rsp_data, e.data);
                check({tag, "_rsp_err"}, bus.rsp_err, {31'd0, e.err});
                check({tag, "_ready_in_rsp"}, bus.req_ready, 32'd0);
                if (i < rsp_stall) @(negedge clk);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, bus.rsp_valid, 32'd0);
        check({tag, "_ready_back"}, bus.req_ready, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_we        = 1'b0;
        bus.req_funct3    = '0;
        bus.rsp_ready     = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        #2;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Loads.
        run_txn("lb", 32'h8000_0003, 32'h0, 1'b0, F3_B, 32'h80FF_0000, 0, 0,
                1'b0, 32'hFFFF_FF80, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lhu", 32'h8000_0002, 32'h0, 1'b0, F3_HU, 32'hBEEF_1234, 0, 0,
                1'b0, 32'h0000_BEEF, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lh", 32'h8000_0000, 32'h0, 1'b0, F3_H, 32'h1234_8001, 0, 0,
                1'b0, 32'hFFFF_8001, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lbu", 32'h8000_0001, 32'h0, 1'b0, F3_BU, 32'h0000_F100, 0, 0,
                1'b0, 32'h0000_00F1, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lw", 32'h8000_0004, 32'h0, 1'b0, F3_W, 32'hCAFE_F00D, 0, 0,
                1'b0, 32'hCAFE_F00D, 32'h8000_0004, 4'h0, 32'h0);

        // Stores.
        run_txn("sb", 32'h8000_0001, 32'h1234_56A5, 1'b1, F3_B, 32'h0, 0, 0,
                1'b0, 32'h0, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5);
        run_txn("sh", 32'h8000_0002, 32'h0000_C3D4, 1'b1, F3_H, 32'h0, 0, 0,
                1'b0, 32'h0, 32'h8000_0000, 4'b1100, 32'hC3D4_C3D4);
        run_txn("sw", 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, F3_W, 32'h0, 0, 0,
                1'b0, 32'h0, 32'h8000_0010, 4'b1111, 32'hDEAD_BEEF);

        // Trapped accesses.
        run_txn("lw_mis", 32'h8000_0002, 32'h0, 1'b0, F3_W, 32'h0, 0, 0,
                1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        run_txn("f3_011", 32'h8000_0000, 32'h0, 1'b0, 3'b011, 32'h0, 0, 0,
                1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        run_txn("sbu", 32'h8000_0000, 32'h55, 1'b1, F3_BU, 32'h0, 0, 1,
                1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        run_txn("lh_mis", 32'h8000_0001, 32'h0, 1'b0, F3_H, 32'h0, 0, 0,
                1'b1, 32'h0, 32'h0, 4'h0, 32'h0);

        // Stalls on both the bus request and the response.
        run_txn("stall", 32'h8000_0002, 32'h0000_7E5A, 1'b1, F3_H, 32'h0, 3, 2,
                1'b0, 32'h0, 32'h8000_0000, 4'b1100, 32'h7E5A_7E5A);
        run_txn("stall_ld", 32'h8000_0008, 32'h0, 1'b0, F3_W, 32'h0BAD_CAFE, 3, 2,
                1'b0, 32'h0BAD_CAFE, 32'h8000_0008, 4'h0, 32'h0);

        // Reset while waiting for the memory response.
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h8000_0004;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        @(negedge clk);
        bus.req_valid     = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("rstw_in_wait", bus.mem_req_valid, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rstw_async");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check_reset_vals("rstw_late_rsp");
        @(negedge clk);
        check_reset_vals("rstw_settled");
        check("sb_drained", sb_q.size(), 32'd0);

        // A normal access still works after the abandoned one.
        run_txn("post_rst", 32'h8000_0003, 32'h0, 1'b0, F3_BU, 32'h80FF_0000, 0, 0,
                1'b0, 32'h0000_0080, 32'h8000_0000, 4'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
